// File: rtl/noc_pkg.sv
// Shared constants and types for the virtual-channel link transmitter.
package noc_pkg;

    localparam int NOC_DATA_W   = 16;
    localparam int NOC_NUM_VC   = 2;
    localparam int NOC_VC_DEPTH = 4;

    // Every credit counter is this wide, which caps the buffer depth at 15.
    localparam int CRED_W = 4;

    // Width of a VC index; a single VC still gets a one-bit tag.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NOC_VC_W = idx_w(NOC_NUM_VC);

    // One link flit as it leaves the block.
    typedef struct packed {
        logic [NOC_DATA_W-1:0] data;
        logic [NOC_VC_W-1:0]   vc_id;
    } flit_t;

endpackage

// File: rtl/noc_rr_arb.sv
// Round-robin arbiter: the search starts just after the last granted requester.
module noc_rr_arb
    import noc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IDX_W = idx_w(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel;
    logic             found;

    // Pick the first requester after the pointer; move the pointer only when a grant is consumed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                grant[(int'(ptr_q) + i) % N] = 1'b1;
                sel = IDX_W'((int'(ptr_q) + i) % N);
            end
        end
        ptr_d = (advance && found) ? sel : ptr_q;
    end

    // Pointer register; resets to the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= IDX_W'(N - 1);
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/noc_vc_tx.sv
// Credit-based multi-VC link transmitter: arbitrates per-VC sources onto one registered link.
module noc_vc_tx
    import noc_pkg::*;
#(
    parameter int DATA_W   = NOC_DATA_W,
    parameter int NUM_VC   = NOC_NUM_VC,
    parameter int VC_DEPTH = NOC_VC_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        in_valid,
    input  logic [NUM_VC*DATA_W-1:0] in_data,
    output logic [NUM_VC-1:0]        in_ready,
    output logic                     enable,
    output logic [DATA_W-1:0]        data,
    output logic [idx_w(NUM_VC)-1:0] vc_id,
    input  logic [NUM_VC-1:0]        credit,
    output logic                     credit_err,
    output logic [NUM_VC*CRED_W-1:0] credit_cnt
);

    localparam int VC_W = idx_w(NUM_VC);
    localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(VC_DEPTH);

    logic [CRED_W-1:0] cnt_q [NUM_VC];
    logic [CRED_W-1:0] cnt_d [NUM_VC];
    logic              err_q, err_d;
    logic              enable_q, enable_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [VC_W-1:0]   vc_id_q, vc_id_d;

    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] grant;
    logic              advance;

    // A VC may compete only with a pending flit and a free downstream slot; nothing competes in reset.
    always_comb begin
        req = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            req[v] = rst && in_valid[v] && (cnt_q[v] != '0);
        end
    end

    // Grants are only issued to valid requesters, so any grant is a handshake.
    assign in_ready = grant;
    assign advance  = |grant;

    noc_rr_arb #(.N(NUM_VC)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    // Credit bookkeeping: a send and a returned credit in one cycle cancel out.
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < NUM_VC; v++) begin
            cnt_d[v] = cnt_q[v];
            if (grant[v] && !credit[v]) begin
                cnt_d[v] = cnt_q[v] - CRED_W'(1);
            end else if (!grant[v] && credit[v]) begin
                if (cnt_q[v] == DEPTH_C) err_d = 1'b1;
                else                     cnt_d[v] = cnt_q[v] + CRED_W'(1);
            end
        end
    end

    // Link output stage: capture the granted flit; payload and tag hold when idle.
    always_comb begin
        enable_d = advance;
        data_d   = data_q;
        vc_id_d  = vc_id_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (grant[v]) begin
                data_d  = in_data[v*DATA_W +: DATA_W];
                vc_id_d = VC_W'(v);
            end
        end
    end

    // State registers; the async reset drops the link strobe without waiting for an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= DEPTH_C;
            err_q    <= 1'b0;
            enable_q <= 1'b0;
            data_q   <= '0;
            vc_id_q  <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= cnt_d[v];
            err_q    <= err_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            vc_id_q  <= vc_id_d;
        end
    end

    // Flatten counters for the status port.
    always_comb begin
        credit_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) credit_cnt[v*CRED_W +: CRED_W] = cnt_q[v];
    end

    assign enable     = enable_q;
    assign data       = data_q;
    assign vc_id      = vc_id_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_noc_vc_tx.sv
// Directed bench for noc_vc_tx with default parameters (DATA_W=16, NUM_VC=2, VC_DEPTH=4).
module tb_noc_vc_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_ready;
    logic        enable;
    logic [15:0] data;
    logic [0:0]  vc_id;
    logic [1:0]  credit;
    logic        credit_err;
    logic [7:0]  credit_cnt;

    int n_vec = 0;
    int n_bad = 0;

    noc_vc_tx dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .enable     (enable),
        .data       (data),
        .vc_id      (vc_id),
        .credit     (credit),
        .credit_err (credit_err),
        .credit_cnt (credit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 2'b00;
        in_data  = '0;
        credit   = 2'b00;

        // Reset state, with requests present to show in_ready stays low.
        step();
        step();
        in_valid = 2'b11;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_enable", 32'(enable), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_vc_id", 32'(vc_id), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);
        chk("rst_cnt", 32'(credit_cnt), 32'h44);
        in_valid = 2'b00;
        step();
        rst = 1'b1;
        step();

        // Both VCs requesting: grants alternate starting at VC0.
        in_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            in_data = {16'hB000 + 16'(i), 16'hA000 + 16'(i)};
            #1;
            chk("alt_ready", 32'(in_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            chk("alt_enable", 32'(enable), 32'h1);
            chk("alt_vc_id", 32'(vc_id), 32'(i % 2));
            chk("alt_data", 32'(data), (i % 2 == 0) ? 32'hA000 + 32'(i) : 32'hB000 + 32'(i));
        end
        in_valid = 2'b00;
        step();
        chk("alt_idle_enable", 32'(enable), 32'h0);
        chk("alt_idle_data_hold", 32'(data), 32'hB003);
        chk("alt_cnt", 32'(credit_cnt), 32'h22);

        // Refill both VCs to full.
        credit = 2'b11;
        step();
        step();
        credit = 2'b00;
        chk("refill_cnt", 32'(credit_cnt), 32'h44);
        chk("refill_err", 32'(credit_err), 32'h0);

        // Extra credit on a full VC1 sets the sticky error.
        credit = 2'b10;
        step();
        credit = 2'b00;
        chk("ovf_err", 32'(credit_err), 32'h1);
        chk("ovf_cnt", 32'(credit_cnt), 32'h44);
        step();
        chk("ovf_err_sticky", 32'(credit_err), 32'h1);

        // VC0 alone for 6 cycles: 4 flits then blocked.
        in_valid = 2'b01;
        in_data  = 32'h0000_C0DE;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("vc0_ready", 32'(in_ready), (i < 4) ? 32'h1 : 32'h0);
            step();
            chk("vc0_enable", 32'(enable), (i < 4) ? 32'h1 : 32'h0);
        end
        chk("vc0_cnt", 32'(credit_cnt), 32'h40);

        // Blocked VC0 does not hold up VC1.
        in_valid = 2'b11;
        in_data  = 32'h1234_C0DE;
        #1;
        chk("hol_ready", 32'(in_ready), 32'h2);
        step();
        chk("hol_enable", 32'(enable), 32'h1);
        chk("hol_vc_id", 32'(vc_id), 32'h1);
        chk("hol_data", 32'(data), 32'h1234);
        chk("hol_cnt", 32'(credit_cnt), 32'h30);

        // Credit to a starved VC0 makes it eligible only on the next cycle.
        in_valid = 2'b01;
        in_data  = 32'h0000_5A5A;
        credit   = 2'b01;
        #1;
        chk("wake_same_cycle", 32'(in_ready), 32'h0);
        step();
        credit = 2'b00;
        #1;
        chk("wake_next_cycle", 32'(in_ready), 32'h1);
        step();
        chk("wake_enable", 32'(enable), 32'h1);
        chk("wake_vc_id", 32'(vc_id), 32'h0);
        chk("wake_data", 32'(data), 32'h5A5A);
        chk("wake_cnt", 32'(credit_cnt), 32'h30);
        #1;
        chk("wake_blocked_again", 32'(in_ready), 32'h0);

        // VC0 at 2 credits: simultaneous send and credit leave the counter alone.
        in_valid = 2'b00;
        credit   = 2'b01;
        step();
        step();
        chk("sc_pre_cnt", 32'(credit_cnt), 32'h32);
        in_valid = 2'b01;
        in_data  = 32'h0000_7777;
        #1;
        chk("sc_ready", 32'(in_ready), 32'h1);
        step();
        credit   = 2'b00;
        in_valid = 2'b00;
        chk("sc_cnt", 32'(credit_cnt), 32'h32);
        chk("sc_enable", 32'(enable), 32'h1);
        chk("sc_vc_id", 32'(vc_id), 32'h0);
        chk("sc_err_still", 32'(credit_err), 32'h1);

        // Reset in the middle of a transfer.
        in_valid = 2'b11;
        in_data  = 32'hBEEF_AAAA;
        step();
        chk("mid_enable_pre", 32'(enable), 32'h1);
        chk("mid_vc_id_pre", 32'(vc_id), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_enable_async", 32'(enable), 32'h0);
        chk("mid_data_async", 32'(data), 32'h0);
        chk("mid_err_async", 32'(credit_err), 32'h0);
        chk("mid_ready_in_rst", 32'(in_ready), 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("post_cnt", 32'(credit_cnt), 32'h44);
        chk("post_ready", 32'(in_ready), 32'h1);
        step();
        chk("post_enable", 32'(enable), 32'h1);
        chk("post_vc_id", 32'(vc_id), 32'h0);
        chk("post_data", 32'(data), 32'hAAAA);
        in_valid = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
